// File: rtl/gray_decoder_chk.sv
// Gray-to-binary decoder with step-integrity checker and lock tracking.
// Optional macro GRAY_DEC_DOWN_EN makes -1 steps legal; otherwise only +1 and hold are legal.
module gray_decoder_chk #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned RESYNC_N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gray_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             dir_up,
  output logic             step_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned GOOD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOST  = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic [GOOD_W-1:0]  good_q, good_n;
  logic [WIDTH-1:0]   prev_q, prev_n;
  logic [WIDTH-1:0]   bin_n;
  logic               bin_valid_n;
  logic               dir_n;
  logic               step_err_n;
  logic               locked_n;
  logic [ERR_W-1:0]   err_n;

  logic [WIDTH-1:0]   bin_c;
  logic               is_up_c;
  logic               is_down_c;
  logic               is_hold_c;
  logic               is_legal_c;
  logic [GOOD_W-1:0]  good_inc_c;

  // Each binary bit is the XOR of all Gray bits at and above it
  always_comb begin
    bin_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      bin_c[i] = ^(gray_in >> i);
    end
  end

  // Step classification, modulo 2^WIDTH
  always_comb begin
    is_up_c    = (bin_c == prev_q + WIDTH'(1));
    is_hold_c  = (bin_c == prev_q);
`ifdef GRAY_DEC_DOWN_EN
    is_down_c  = (bin_c == prev_q - WIDTH'(1));
`else
    is_down_c  = 1'b0;
`endif
    is_legal_c = is_up_c | is_down_c | is_hold_c;
    good_inc_c = good_q + GOOD_W'(1);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n     = state_q;
    good_n      = good_q;
    prev_n      = prev_q;
    bin_n       = bin_out;
    bin_valid_n = 1'b0;
    dir_n       = dir_up;
    step_err_n  = 1'b0;
    err_n       = err_count;

    if (gray_valid) begin
      bin_n       = bin_c;
      bin_valid_n = 1'b1;
      prev_n      = bin_c;
      case (state_q)
        IDLE: begin
          state_n = LOST;
          good_n  = '0;
        end
        TRACK, LOST: begin
          if (!is_legal_c) begin
            step_err_n = 1'b1;
            state_n    = LOST;
            good_n     = '0;
            if (err_count != {ERR_W{1'b1}}) begin
              err_n = err_count + ERR_W'(1);
            end
          end else begin
            if (is_up_c) begin
              dir_n = 1'b1;
            end else if (is_down_c) begin
              dir_n = 1'b0;
            end
            // Only real movement counts toward regaining lock
            if (state_q == LOST && (is_up_c || is_down_c)) begin
              if (good_inc_c >= GOOD_W'(RESYNC_N)) begin
                state_n = TRACK;
                good_n  = '0;
              end else begin
                good_n  = good_inc_c;
              end
            end
          end
        end
        default: begin
          state_n = IDLE;
          good_n  = '0;
        end
      endcase
    end

    locked_n = (state_n == TRACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      good_q    <= '0;
      prev_q    <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      dir_up    <= 1'b1;
      step_err  <= 1'b0;
      locked    <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_n;
      good_q    <= good_n;
      prev_q    <= prev_n;
      bin_out   <= bin_n;
      bin_valid <= bin_valid_n;
      dir_up    <= dir_n;
      step_err  <= step_err_n;
      locked    <= locked_n;
      err_count <= err_n;
    end
  end

endmodule

// File: doc/gray_decoder_chk.md
# gray_decoder_chk

- Receive-side companion to the team's Gray counter: decodes a Gray-coded sample stream back to binary and checks sequence integrity.
- Each valid step must be a single-step change (+1, or −1 when enabled) or a hold. Illegal steps are flagged, counted and trigger loss of lock.
- Sits after any Gray-encoded counter or pointer crossing into the `clk` domain; feeds monitors and FIFO pointer logic.

## Interface
Parameters:
- `WIDTH`, 4, Gray/binary word width (2..16)
- `ERR_W`, 8, error counter width
- `RESYNC_N`, 2, consecutive legal steps required to regain lock (1..15)

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `gray_in` in WIDTH: Gray-coded input sample.
- `gray_valid` in 1: `gray_in` valid this cycle.
- `bin_out` out WIDTH: decoded binary, registered.
- `bin_valid` out 1: one-cycle pulse, `bin_out` and status updated.
- `dir_up` out 1: direction of last non-hold legal step (1 = up).
- `step_err` out 1: one-cycle pulse with `bin_valid` when the sample was an illegal step.
- `locked` out 1: checker in TRACK state.
- `err_count` out ERR_W: saturating count of illegal steps.

## Operation
- Decode is combinational: `b[W-1] = g[W-1]`, `b[i] = b[i+1] ^ g[i]`. The result is registered into `bin_out` on every cycle where `gray_valid` = 1.
- `prev` is the previously accepted binary value. Step classification uses modulo 2^WIDTH arithmetic:
  - UP: `b == prev+1`. Wrap from all-ones to 0 is legal.
  - DOWN: `b == prev−1`. Wrap from 0 to all-ones is legal.
  - HOLD: `b == prev`. Legal; `dir_up` unchanged.
  - ILLEGAL: anything else.
- State machine, advanced only on `gray_valid` = 1:
  - IDLE: the first sample loads `prev`. No check, no `step_err`. Next state is LOST with good-count 0.
  - TRACK: a legal step stays in TRACK. An illegal step raises `step_err`, increments `err_count`, and moves to LOST with good-count 0.
  - LOST: an UP or DOWN step increments good-count; reaching RESYNC_N moves to TRACK. HOLD leaves good-count unchanged. An illegal step raises `step_err`, increments `err_count`, and clears good-count.
- `prev` is updated with `b` on every valid sample, legal or not, so resync follows the new sequence.
- `err_count` saturates at 2^ERR_W−1 and never wraps.
- `locked` = 1 only in TRACK.
- `gray_valid` = 0: no state, `prev`, counter or output change; `bin_valid` = 0, `step_err` = 0.

## Timing
- Latency is 1 cycle: a sample accepted at edge N gives `bin_out`, `bin_valid`, `step_err`, `dir_up`, `locked` and `err_count` updated after edge N.
- Back-to-back `gray_valid` is supported at full rate, one sample per cycle. There is no backpressure.
- Values after reset:
  - `bin_out` = 0, `bin_valid` = 0, `step_err` = 0
  - `dir_up` = 1, `locked` = 0, `err_count` = 0
  - state IDLE, `prev` = 0, good-count 0
- `rst` asserted together with `gray_valid`: reset wins and the sample is dropped.
- Reset mid-stream: the next valid sample after deassertion is treated as the first sample (IDLE).
- `step_err` and the `err_count` increment appear in the same cycle. Counter saturation does not suppress `step_err`.

## Configuration
- Macro `GRAY_DEC_DOWN_EN`:
  - Defined: DOWN steps are legal, and `dir_up` tracks direction as described.
  - Undefined: DOWN steps are classified ILLEGAL and `dir_up` is tied to 1. Only UP and HOLD are legal, matching the up-only Gray counter.

## Test plan
- Reset, then feed the 16-value Gray up-sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0 on consecutive cycles. Expected: `bin_out` 0..15,0 with 1-cycle latency; `locked` rises after the 3rd sample (RESYNC_N = 2); `step_err` never asserted; legal wrap 15→0.
- While locked at Gray 7 (bin 5), inject Gray F (bin 10). Expected: `step_err` pulse, `err_count` = 1, `locked` = 0. Next samples E, A (bin 11, 12) make `locked` = 1 again.
- Repeat Gray 6 for 3 cycles, then `gray_valid` = 0 for 4 cycles. Expected: HOLD gives no error, `dir_up` unchanged; idle cycles give `bin_valid` = 0 and no state change.
- Down sequence 8,9,B,A (bin 15,14,13,12). With `GRAY_DEC_DOWN_EN`: `dir_up` = 0, no errors. Without it: 3 `step_err` pulses, `err_count` = 3.
- ERR_W = 2: inject 5 illegal steps. Expected: `err_count` saturates at 3, 5 `step_err` pulses.
- Assert `rst` in the same cycle as `gray_valid` mid-stream. Expected: all outputs at reset values next cycle; the following sample gives `bin_valid` with no `step_err`, whatever its value.
